// File: rtl/lock_attempt_ctrl.sv
// Attempt sequencer for the digital lock's password-check path.
// Detects each ENTER press, applies the compare result, tracks consecutive
// failures and runs timed OPEN and LOCKOUT windows off a shared prescaler.
module lock_attempt_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int OPEN_TICKS = 5,
  parameter int LOCK_TICKS = 30,
  parameter int MAX_TRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       enter,
  input  logic       pass_ok,
  output logic       unlock,
  output logic       alarm,
  output logic       busy,
  output logic [2:0] fail_cnt,
  output logic [2:0] led_4
);

  localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_TICKS = (OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 0) ? $clog2(MAX_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       fail_nxt;
  logic [PRE_W-1:0] presc;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             open_done;
  logic             lock_done;

  logic             enter_p0;
  logic             enter_q;
  logic             press;

  // Status LED pattern for a given state and failure count.
  function automatic logic [2:0] led_decode(input state_t s, input logic [2:0] f);
    logic [2:0] led;
    led = 3'b000;
    case (s)
      OPEN:    led = 3'b010;
      LOCKOUT: led = 3'b111;
      default: begin
        if (f == 3'd0)      led = 3'b000;
        else if (f == 3'd1) led = 3'b001;
        else                led = 3'b101;
      end
    endcase
    return led;
  endfunction

  // ---- stage p0: sample ENTER, detect its rising edge ----
  // enter_p0/enter_q reset high so ENTER held through reset is not a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_p0 <= 1'b1;
      enter_q  <= 1'b1;
    end else begin
      enter_p0 <= enter;
      enter_q  <= enter_p0;
    end
  end

  assign press = enter_p0 & ~enter_q;

  // ---- stage p1: timer compare and next-state decision ----
  assign tick      = (presc == PRE_W'(TICK_DIV - 1));
  assign open_done = tick && ((tick_cnt + CNT_W'(1)) == CNT_W'(OPEN_TICKS));
  assign lock_done = tick && ((tick_cnt + CNT_W'(1)) == CNT_W'(LOCK_TICKS));

  // Next state and failure count; expiry takes priority over a coincident press.
  always_comb begin
    state_nxt = state;
    fail_nxt  = fail_cnt;
    case (state)
      IDLE: begin
        if (press && !mode) begin
          if (pass_ok) begin
            state_nxt = OPEN;
            fail_nxt  = 3'd0;
          end else if ((fail_cnt + 3'd1) == 3'(MAX_TRIES)) begin
            state_nxt = LOCKOUT;
            fail_nxt  = 3'(MAX_TRIES);
          end else begin
            fail_nxt  = fail_cnt + 3'd1;
          end
        end
      end
      OPEN: begin
        if (open_done || (press && !mode)) begin
          state_nxt = IDLE;
        end
      end
      LOCKOUT: begin
        if (lock_done) begin
          state_nxt = IDLE;
          fail_nxt  = 3'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        fail_nxt  = 3'd0;
      end
    endcase
  end

  // ---- stage p2: state, timers and outputs registered from the next state ----
  // Timers restart on every state change and stay cleared while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fail_cnt <= 3'd0;
      presc    <= '0;
      tick_cnt <= '0;
      unlock   <= 1'b0;
      alarm    <= 1'b0;
      busy     <= 1'b0;
      led_4    <= 3'b000;
    end else begin
      state    <= state_nxt;
      fail_cnt <= fail_nxt;
      if ((state_nxt != state) || (state_nxt == IDLE)) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + CNT_W'(1);
      end else begin
        presc    <= presc + PRE_W'(1);
      end
      unlock <= (state_nxt == OPEN);
      alarm  <= (state_nxt == LOCKOUT);
      busy   <= (state_nxt == OPEN) || (state_nxt == LOCKOUT);
      led_4  <= led_decode(state_nxt, fail_nxt);
    end
  end

endmodule
